instr_encoder: RTL and testbench

- Inverse of the main control decoder: turns decoded instruction fields (class, funct3, funct7 bit 5, rd, rs1, rs2, signed immediate) back into 32-bit RV32I machine words.
- Streams the words into instruction memory at consecutive word addresses.
- Used as the program loader and self-test source that fills instruction RAM before the CPU is released from reset.
- Has a valid/ready field input, a registered valid/ready memory-write output, and a sequencing FSM.

---
 rtl/instr_encoder.sv | 171 +++++++++++++++++
 tb/tb_instr_encoder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into machine words and streams them
// into instruction RAM at consecutive word addresses, starting at BASE_ADDR.
// Define INSTR_ENCODER_CHECK_EN to reject illegal beats and drive the err flag.
module instr_encoder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000,
  parameter int unsigned           MAX_INSTR  = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [2:0]                       iclass,
  input  logic [2:0]                       funct3,
  input  logic                             funct7b5,
  input  logic [4:0]                       rd,
  input  logic [4:0]                       rs1,
  input  logic [4:0]                       rs2,
  input  logic [20:0]                      imm,
  output logic                             wr_en,
  input  logic                             wr_ready,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [31:0]                      wr_data,
  output logic [$clog2(MAX_INSTR+1)-1:0]   count,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int unsigned CW = $clog2(MAX_INSTR + 1);

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_IALU  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h00000013;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           enc;
  logic                  is_shift;
  logic                  bad;
  logic                  accept;
  logic                  wr_accept;
  logic                  complete;
  logic [CW:0]           total;

  assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign in_ready  = (state == S_RUN) && (!wr_en || wr_ready);
  assign accept    = in_valid && in_ready;
  assign wr_accept = accept && !bad;
  assign complete  = wr_en && wr_ready;
  // Words written plus the one pending after this beat registers.
  assign total     = {1'b0, count} + (CW+1)'(wr_en) + (CW+1)'(1);

  // Field placement per instruction class; unknown classes become a NOP.
  always_comb begin
    enc = NOP;
    case (iclass)
      3'd0: enc = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      3'd1: begin
        if (is_shift) enc = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IALU};
        else          enc = {imm[11:0], rs1, funct3, rd, OP_IALU};
      end
      3'd2: enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      3'd3: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      3'd4: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: enc = NOP;
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic signed [20:0] imm_s;
  logic               out12;

  assign imm_s = $signed(imm);
  assign out12 = (imm_s < -21'sd2048) || (imm_s > 21'sd2047);

  // Legality of the immediate for the beat's class.
  always_comb begin
    bad = 1'b0;
    case (iclass)
      3'd1: begin
        if (is_shift) bad = (imm_s < 21'sd0) || (imm_s > 21'sd31);
        else          bad = out12;
      end
      3'd2, 3'd3: bad = out12;
      3'd4: bad = (imm_s < -21'sd4096) || (imm_s > 21'sd4094) || imm[0];
      3'd5: bad = imm[0];
      3'd6, 3'd7: bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  // Sticky error, cleared when a new run starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start && (state == S_IDLE || state == S_DONE)) begin
      err <= 1'b0;
    end else if (accept && bad) begin
      err <= 1'b1;
    end
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  // Run sequencing and the registered memory-write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= 32'h0;
      next_addr <= BASE_ADDR;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            wr_addr   <= BASE_ADDR;
            next_addr <= BASE_ADDR;
            count     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_RUN: begin
          if (complete) begin
            count <= count + CW'(1);
            wr_en <= 1'b0;
          end
          if (wr_accept) begin
            wr_en     <= 1'b1;
            wr_data   <= enc;
            wr_addr   <= next_addr;
            next_addr <= next_addr + ADDR_WIDTH'(4);
          end
          if (accept && (in_last || (wr_accept && total == (CW+1)'(MAX_INSTR)))) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (complete) begin
            count <= count + CW'(1);
            wr_en <= 1'b0;
          end
          if (!wr_en || wr_ready) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed bench for instr_encoder, checked
// against a transaction-level reference model (expected-write queue).
module tb_instr_encoder;

  localparam int unsigned MAXI = 256;
  localparam logic [31:0] BASE = 32'hBFC00000;
`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, funct7b5, wr_ready;
  logic [2:0]  iclass, funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [20:0] imm;
  logic        in_ready, wr_en, busy, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [8:0]  count;

  int imm_v;
  bit rdy_rand;
  bit poke_start;
  bit chk_en;
  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  int          m_state;   // 0 idle, 1 run, 2 drain, 3 done
  int unsigned m_addr;
  int          m_count;
  bit          m_err;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .iclass(iclass), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding computed from integer field values.
  function automatic logic [31:0] ref_enc(input int unsigned c, f3, f7, rdv, r1, r2, input int v);
    int unsigned u;
    int unsigned w;
    u = unsigned'(v);
    case (c)
      0: w = (f7 << 30) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h33;
      1: begin
        if (f3 == 1 || f3 == 5)
          w = (f7 << 30) | ((u & 31) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h13;
        else
          w = ((u & 4095) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h13;
      end
      2: w = ((u & 4095) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | 32'h03;
      3: w = (((u >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             ((u & 31) << 7) | 32'h23;
      4: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15) |
             (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
             (((u >> 12) & 255) << 12) | (rdv << 7) | 32'h6F;
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  function automatic bit ref_bad(input int c, input int f3, input int v);
    if (c > 5) return 1'b1;
    if (c == 1 && (f3 == 1 || f3 == 5)) return (v < 0) || (v > 31);
    if (c == 1 || c == 2 || c == 3) return (v < -2048) || (v > 2047);
    if (c == 4) return (v < -4096) || (v > 4094) || (v % 2 != 0);
    if (c == 5) return (v % 2 != 0);
    return 1'b0;
  endfunction

  // Compare outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin : model
    bit exp_rdy;
    bit acc;
    bit bad;
    exp_rdy = (m_state == 1) && ((q.size() == 0) || wr_ready);
    if (chk_en) begin
      check("wr_en", 32'(wr_en), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
      check("done", 32'(done), 32'(m_state == 3));
      check("count", 32'(count), 32'(m_count));
      check("err", 32'(err), 32'(m_err));
      if (q.size() != 0) begin
        check("wr_addr", wr_addr, q[0].a);
        check("wr_data", wr_data, q[0].d);
      end
    end
    if (rst) begin
      m_state = 0; m_addr = BASE; m_count = 0; m_err = 1'b0; q.delete();
    end else begin
      case (m_state)
        0, 3: if (start) begin
          m_state = 1; m_addr = BASE; m_count = 0; m_err = 1'b0;
        end
        1: begin
          acc = in_valid && exp_rdy;
          if (q.size() != 0 && wr_ready) begin
            void'(q.pop_front());
            m_count++;
          end
          if (acc) begin
            bad = CHK && ref_bad(32'(iclass), 32'(funct3), imm_v);
            if (bad) m_err = 1'b1;
            else begin
              q.push_back('{a: m_addr,
                            d: ref_enc(32'(iclass), 32'(funct3), 32'(funct7b5), 32'(rd),
                                       32'(rs1), 32'(rs2), imm_v)});
              m_addr += 4;
            end
            if (in_last || (!bad && (m_count + q.size()) == MAXI)) m_state = 2;
          end
        end
        2: begin
          if (q.size() == 0) m_state = 3;
          else if (wr_ready) begin
            void'(q.pop_front());
            m_count++;
            m_state = 3;
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_beat(input int c, f3, f7, rdv, r1, r2, v, input bit last);
    iclass = 3'(c); funct3 = 3'(f3); funct7b5 = 1'(f7);
    rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2);
    imm_v = v; imm = 21'(v); in_last = last;
  endtask

  // Present the current beat until the DUT takes it (bounded).
  task automatic push_beat();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      start = poke_start && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      tick();
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_beat(input bit legal, input bit last);
    int c;
    int f3;
    int v;
    c  = legal ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 7));
    f3 = int'($urandom_range(0, 7));
    if (!legal && $urandom_range(0, 3) == 0) v = int'($urandom_range(0, 2097151)) - 1048576;
    else begin
      case (c)
        1: v = (f3 == 1 || f3 == 5) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
        2, 3: v = int'($urandom_range(0, 4095)) - 2048;
        4: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        5: v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        default: v = int'($urandom_range(0, 2097151)) - 1048576;
      endcase
    end
    set_beat(c, f3, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), v, last);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    rdy_rand = 1'b0; poke_start = 1'b0; chk_en = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;

    // First word, one-cycle latency
    start_run();
    set_beat(1, 0, 0, 1, 0, 0, 5, 1'b1);
    push_beat();
    @(negedge clk);
    check("addi_en", 32'(wr_en), 32'd1);
    check("addi_addr", wr_addr, BASE);
    check("addi_data", wr_data, 32'h00500093);
    tick();
    wait_done();
    check("addi_count", 32'(count), 32'd1);

    // Back-to-back ADD / SUB
    start_run();
    set_beat(0, 0, 0, 3, 1, 2, 0, 1'b0);
    push_beat();
    set_beat(0, 0, 1, 3, 1, 2, 0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    check("add_data", wr_data, 32'h002081B3);
    check("add_addr", wr_addr, BASE);
    check("add_b2b_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sub_data", wr_data, 32'h402081B3);
    check("sub_addr", wr_addr, BASE + 32'd4);
    tick();
    wait_done();
    check("addsub_count", 32'(count), 32'd2);

    // Branch, then a 3-cycle memory stall with the JAL beat waiting
    start_run();
    set_beat(4, 1, 0, 0, 1, 0, -8, 1'b0);
    push_beat();
    wr_ready = 1'b0;
    set_beat(5, 0, 0, 0, 0, 0, -8, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data", wr_data, 32'hFE009CE3);
      check("stall_addr", wr_addr, BASE);
      check("stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    wr_ready = 1'b1;
    @(negedge clk);
    check("br_data", wr_data, 32'hFE009CE3);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("jal_data", wr_data, 32'hFF9FF06F);
    check("jal_addr", wr_addr, BASE + 32'd4);
    tick();
    wait_done();
    check("brjal_count", 32'(count), 32'd2);

    // in_last on the third beat
    start_run();
    for (int k = 0; k < 3; k++) begin
      rand_beat(1'b1, k == 2);
      push_beat();
    end
    wait_done();
    check("last3_count", 32'(count), 32'd3);
    check("last3_done", 32'(done), 32'd1);

    // Reset during a stalled write
    start_run();
    rand_beat(1'b1, 1'b0);
    push_beat();
    wr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", wr_addr, BASE);
    check("mid_rst_data", wr_data, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    tick();
    wr_ready = 1'b1;

    // Out-of-range I immediate followed by a legal word
    start_run();
    set_beat(1, 0, 0, 1, 0, 0, 2048, 1'b0);
    push_beat();
    @(negedge clk);
`ifdef INSTR_ENCODER_CHECK_EN
    check("rej_wr_en", 32'(wr_en), 32'd0);
    check("rej_err", 32'(err), 32'd1);
`else
    check("imm2048_data", wr_data, 32'h80000093);
    check("imm2048_addr", wr_addr, BASE);
`endif
    tick();
    set_beat(1, 0, 0, 1, 0, 0, 5, 1'b1);
    push_beat();
    @(negedge clk);
    check("after_data", wr_data, 32'h00500093);
`ifdef INSTR_ENCODER_CHECK_EN
    check("after_addr", wr_addr, BASE);
`else
    check("after_addr", wr_addr, BASE + 32'd4);
`endif
    tick();
    wait_done();

    // Random runs with random back-pressure and ignored start pulses
    rdy_rand = 1'b1;
    poke_start = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      start_run();
      for (int k = 0; k < n; k++) begin
        rand_beat(1'b0, k == n - 1);
        push_beat();
      end
      wait_done();
    end

    // Forced stop at MAX_INSTR without in_last
    start_run();
    for (int k = 0; k < MAXI; k++) begin
      rand_beat(1'b1, 1'b0);
      push_beat();
    end
    wait_done();
    check("max_count", 32'(count), 32'(MAXI));

    poke_start = 1'b0;
    rdy_rand = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
